// File: rtl/workgroup_pkg.sv
// Shared workgroup definitions: configuration limits and the L2 flush
// arbiter state encoding.
package workgroup_pkg;

    // Upper bound on the number of harts a workgroup can host.
    localparam int CFG_CPU_MAX = 16;

    // Flush arbiter states: collect requests, offer the command, wait for
    // the L2 to report completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } flush_state_e;

endpackage : workgroup_pkg

// File: rtl/l2_flush_arbiter.sv
// L2 flush arbiter: merges per-hart flush requests into single L2 flush
// commands and returns a one-cycle completion pulse to every hart served.
// Requests arriving while a flush is in flight are held for the next one.
//
// Optional watchdog: define L2_FLUSH_ARBITER_TIMEOUT_EN to abort a flush
// whose completion never arrives (acks the harts and pulses o_flush_err).
// Without the macro the arbiter waits for i_flush_done indefinitely.
import workgroup_pkg::*;

module l2_flush_arbiter #(
    parameter int hart_num     = 4,   // 1 .. CFG_CPU_MAX
    parameter int timeout_bits = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [hart_num-1:0] i_flush_req,
    output logic [hart_num-1:0] o_flush_ack,
    output logic                o_flush_valid,
    input  logic                i_flush_accept,
    input  logic                i_flush_done,
    output logic [hart_num-1:0] o_flush_src,
    output logic                o_busy,
    output logic                o_flush_err
);

    flush_state_e        state_q, state_d;
    logic [hart_num-1:0] pending_q, pending_d;
    logic [hart_num-1:0] served_q, served_d;
    logic [hart_num-1:0] ack_q, ack_d;
    logic [hart_num-1:0] req_all;
    logic [hart_num-1:0] cleared;
    logic                expire;

    // Everything asking for a flush right now, including this cycle's requests.
    assign req_all = pending_q | i_flush_req;

`ifdef L2_FLUSH_ARBITER_TIMEOUT_EN
    localparam logic [timeout_bits-1:0] CNT_MAX  = '1;
    localparam logic [timeout_bits-1:0] CNT_LAST = CNT_MAX - 1'b1;

    logic [timeout_bits-1:0] cnt_q, cnt_d;
    logic                    err_q, err_d;

    // Watchdog counter: zeroed as the flush is accepted, counts WAIT cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == REQ && i_flush_accept) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expiry is the WAIT cycle whose increment would land on all-ones, so
    // the abort follows exactly 2**timeout_bits - 1 WAIT cycles. A done in
    // that same cycle takes priority and suppresses the error.
    assign expire = (state_q == WAIT) && (cnt_q == CNT_LAST);
    assign err_d  = expire && !i_flush_done;

    // Watchdog registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_flush_err = !i_rst && err_q;
`else
    logic unused_cfg;

    assign unused_cfg  = (timeout_bits > 0);
    assign expire      = 1'b0;
    assign o_flush_err = 1'b0;
`endif

    // Next-state logic: pending collection, served latch and ack generation.
    always_comb begin
        state_d  = state_q;
        served_d = served_q;
        ack_d    = '0;
        cleared  = '0;
        case (state_q)
            IDLE: begin
                if (|req_all) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // A done seen here belongs to nothing we issued; ignore it.
                if (i_flush_accept) begin
                    served_d = req_all;
                    cleared  = req_all;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (i_flush_done || expire) begin
                    ack_d   = served_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        pending_d = req_all & ~cleared;
    end

    // Main state registers; reset aborts any flush without acknowledging it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            served_q  <= '0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            served_q  <= served_d;
            ack_q     <= ack_d;
        end
    end

    // Outputs are forced low for as long as reset is held.
    assign o_flush_valid = !i_rst && (state_q == REQ);
    assign o_busy        = !i_rst && (state_q != IDLE);
    assign o_flush_src   = (!i_rst && state_q == WAIT) ? served_q : '0;
    assign o_flush_ack   = i_rst ? '0 : ack_q;

endmodule : l2_flush_arbiter

// File: doc/l2_flush_arbiter.md
L2_FLUSH_ARBITER -- requirements
Module: l2_flush_arbiter

Interface
REQ-001 SHALL have parameter hart_num, default 4, giving the number of hart flush channels (range 1..CFG_CPU_MAX).
REQ-002 SHALL have parameter timeout_bits, default 16, giving the width of the flush watchdog counter.
REQ-003 SHALL have one clock and a synchronous, active-high reset, exposed as the two ports below.
REQ-004 i_clk  in  1  clock; every register updates on its rising edge.
REQ-005 i_rst  in  1  reset; synchronous, active-high.
REQ-006 i_flush_req  in  hart_num  per-hart flush request; a pulse or a level, sampled every cycle.
REQ-007 o_flush_ack  out  hart_num  per-hart completion pulse, 1 cycle long.
REQ-008 o_flush_valid  out  1  flush command to the L2.
REQ-009 i_flush_accept  in  1  L2 has taken the command.
REQ-010 i_flush_done  in  1  L2 flush has completed.
REQ-011 o_flush_src  out  hart_num  mask of the harts served by the current flush.
REQ-012 o_busy  out  1  high in any state other than IDLE.
REQ-013 o_flush_err  out  1  1-cycle pulse when the watchdog expires.

Function
REQ-014 SHALL keep a registered pending mask: pending <= (pending | i_flush_req) & ~cleared.
REQ-015 SHALL implement the states IDLE, REQ and WAIT; o_flush_valid is 1 only in REQ.
REQ-016 IDLE: if (pending | i_flush_req) != 0, the next state SHALL be REQ, so o_flush_valid rises 1 cycle after the first request.
REQ-017 REQ: when i_flush_accept=1, the arbiter SHALL latch served = pending | i_flush_req, clear those bits in pending, and move to WAIT.
REQ-018 REQ: i_flush_done SHALL be ignored, including when it is asserted together with i_flush_accept.
REQ-019 WAIT: new requests SHALL accumulate in pending and be served by the next flush; they are not merged into served.
REQ-020 WAIT: when i_flush_done=1, the arbiter SHALL drive o_flush_ack = served for exactly the next cycle and move to IDLE.
REQ-021 On return to IDLE with pending nonzero, the arbiter SHALL re-enter REQ on the following cycle; back-to-back flushes have exactly 1 IDLE cycle between them.
REQ-022 o_flush_src SHALL equal served in WAIT and SHALL be 0 otherwise.
REQ-023 A hart that requests while its own bit is already pending SHALL be coalesced into one ack.
REQ-024 i_flush_accept and i_flush_done asserted in IDLE SHALL be ignored.

Reset
REQ-025 While i_rst=1: state=IDLE, pending=0, served=0, counter=0, and every output is 0.
REQ-026 Reset asserted mid-operation SHALL abort the flush without any ack; requests sampled during reset are dropped.

Configuration
REQ-027 Macro L2_FLUSH_ARBITER_TIMEOUT_EN defined: a timeout_bits-wide counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-028 On reaching all-ones without i_flush_done, the block SHALL pulse o_flush_ack=served and o_flush_err=1 for 1 cycle and go to IDLE.
REQ-029 If i_flush_done arrives in the same cycle the counter reaches all-ones, done SHALL win and o_flush_err stays 0.
REQ-030 Macro undefined: no counter is implemented, o_flush_err is tied 0, and WAIT lasts until i_flush_done.

Structure
REQ-031 The state enumeration typedef (IDLE/REQ/WAIT) SHALL be defined in workgroup_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; the watchdog is inline, guarded by the macro.
REQ-033 The block SHALL replace the combinational OR of per-hart flush signals inside the workgroup.

Verification
REQ-034 hart_num=4: req=0001 at cycle 0, accept at 2, done at 5 -> o_flush_valid high cycles 1-2; o_flush_ack=0001 at cycle 6.
REQ-035 req=0101 in the same cycle -> single flush; o_flush_src=0101; o_flush_ack=0101 one cycle after done.
REQ-036 req=0001 served, then req=1000 during WAIT -> first ack=0001, 1 IDLE cycle, second flush, ack=1000.
REQ-037 i_flush_accept and i_flush_done both at 1 in REQ -> move to WAIT, no ack; the later done produces the ack.
REQ-038 Timeout macro on, timeout_bits=4, done never asserted -> after 15 WAIT cycles, o_flush_err=1 and o_flush_ack=served together; macro off -> o_busy stays 1 indefinitely.
REQ-039 i_rst pulsed during WAIT -> all outputs 0 next cycle; no ack is emitted; o_busy=0.
